// File: rtl/jtcop_obj_linebuf.sv
// Double-buffered object line buffer: the draw engine fills one bank while the other
// is scanned out to the colour mixer and erased behind the beam.
module jtcop_obj_linebuf #(
  parameter int unsigned AW         = 9,
  parameter int unsigned DW         = 8,
  parameter int unsigned CLR_ON_RST = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic [AW-1:0] hdump,
  input  logic          flip,
  input  logic          buf_we,
  input  logic [AW-1:0] buf_addr,
  input  logic [DW-1:0] buf_data,
  input  logic          draw_busy,
  output logic          line_start,
  output logic          draw_bank,
  output logic          overrun,
  output logic          ready,
  output logic [DW-1:0] obj_pxl
);

  localparam int unsigned   DEPTH     = 2 ** AW;
  localparam logic [AW-1:0] LAST_ADDR = '1;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  localparam state_t RST_STATE = (CLR_ON_RST != 0) ? CLEAR : RUN;
  localparam logic   RST_READY = (CLR_ON_RST == 0);

  logic [DW-1:0] bank0 [DEPTH];
  logic [DW-1:0] bank1 [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          ready_q, ready_d;
  logic          lhbl_q, lhbl_d;
  logic          draw_bank_q, draw_bank_d;
  logic          line_start_q, line_start_d;
  logic          overrun_q, overrun_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_pend_q, rd_pend_d;
  logic [DW-1:0] pxl_q, pxl_d;
  logic [DW-1:0] obj_pxl_q, obj_pxl_d;

  logic          we0_c, we1_c;
  logic [AW-1:0] wa0_c, wa1_c;
  logic [DW-1:0] wd0_c, wd1_c;
  logic          hfall_c, draw_wr_c;
  logic [DW-1:0] rd_data_c;

  // Display bank is always the one the draw engine does not own
  assign rd_data_c = draw_bank_q ? bank0[rd_addr_q] : bank1[rd_addr_q];
  assign hfall_c   = lhbl_q & ~LHBL;
  assign draw_wr_c = buf_we & (buf_data[3:0] != 4'd0);

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    ready_d      = ready_q;
    lhbl_d       = LHBL;
    draw_bank_d  = draw_bank_q;
    line_start_d = 1'b0;
    overrun_d    = 1'b0;
    rd_addr_d    = rd_addr_q;
    rd_pend_d    = 1'b0;
    pxl_d        = pxl_q;
    obj_pxl_d    = obj_pxl_q;
    we0_c        = 1'b0;
    we1_c        = 1'b0;
    wa0_c        = '0;
    wa1_c        = '0;
    wd0_c        = '0;
    wd1_c        = '0;
    case (state_q)
      CLEAR: begin
        we0_c      = 1'b1;
        we1_c      = 1'b1;
        wa0_c      = clr_addr_q;
        wa1_c      = clr_addr_q;
        obj_pxl_d  = '0;
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == LAST_ADDR) state_d = RUN;
      end
      RUN: begin
        ready_d = 1'b1;
        if (hfall_c) begin
          draw_bank_d  = ~draw_bank_q;
          line_start_d = 1'b1;
          overrun_d    = draw_busy;
        end
        // Draw writes use the bank owned before any toggle in this clk
        if (draw_wr_c) begin
          if (draw_bank_q) begin
            we1_c = 1'b1;
            wa1_c = buf_addr;
            wd1_c = buf_data;
          end else begin
            we0_c = 1'b1;
            wa0_c = buf_addr;
            wd0_c = buf_data;
          end
        end
        if (pxl_cen) begin
          if (LHBL) begin
            rd_addr_d = flip ? ~hdump : hdump;
            rd_pend_d = 1'b1;
            obj_pxl_d = pxl_q;
          end else begin
            obj_pxl_d = '0;
          end
        end
        // Capture the display pixel and erase it behind the beam
        if (rd_pend_q) begin
          pxl_d = rd_data_c;
          if (draw_bank_q) begin
            we0_c = 1'b1;
            wa0_c = rd_addr_q;
          end else begin
            we1_c = 1'b1;
            wa1_c = rd_addr_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RST_STATE;
      clr_addr_q   <= '0;
      ready_q      <= RST_READY;
      lhbl_q       <= 1'b0;
      draw_bank_q  <= 1'b0;
      line_start_q <= 1'b0;
      overrun_q    <= 1'b0;
      rd_addr_q    <= '0;
      rd_pend_q    <= 1'b0;
      pxl_q        <= '0;
      obj_pxl_q    <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      ready_q      <= ready_d;
      lhbl_q       <= lhbl_d;
      draw_bank_q  <= draw_bank_d;
      line_start_q <= line_start_d;
      overrun_q    <= overrun_d;
      rd_addr_q    <= rd_addr_d;
      rd_pend_q    <= rd_pend_d;
      pxl_q        <= pxl_d;
      obj_pxl_q    <= obj_pxl_d;
    end
  end

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (we0_c) bank0[wa0_c] <= wd0_c;
    if (we1_c) bank1[wa1_c] <= wd1_c;
  end

  assign line_start = line_start_q;
  assign draw_bank  = draw_bank_q;
  assign overrun    = overrun_q;
  assign ready      = ready_q;
  assign obj_pxl    = obj_pxl_q;

endmodule

// File: tb/tb_jtcop_obj_linebuf.sv
// Directed bench for the object line buffer: clear, draw/scan, erase, flip,
// overrun, swap-coincident write and mid-scan reset.
module tb_jtcop_obj_linebuf;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pxl_cen = 1'b0;
  logic          LHBL = 1'b1;
  logic [AW-1:0] hdump = '0;
  logic          flip = 1'b0;
  logic          buf_we = 1'b0;
  logic [AW-1:0] buf_addr = '0;
  logic [DW-1:0] buf_data = '0;
  logic          draw_busy = 1'b0;
  logic          line_start, draw_bank, overrun, ready;
  logic [DW-1:0] obj_pxl;

  int pass_cnt = 0;
  int total_cnt = 0;

  jtcop_obj_linebuf #(.AW(AW), .DW(DW), .CLR_ON_RST(1)) dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .hdump(hdump),
    .flip(flip), .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data),
    .draw_busy(draw_busy), .line_start(line_start), .draw_bank(draw_bank),
    .overrun(overrun), .ready(ready), .obj_pxl(obj_pxl)
  );

  always #5 clk = ~clk;

  // One pixel: pxl_cen for one clk, then two idle clks (all tasks run from a negedge)
  task automatic pix(input logic [AW-1:0] h);
    hdump   = h;
    pxl_cen = 1'b1;
    @(negedge clk);
    pxl_cen = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    buf_we = 1'b1; buf_addr = a; buf_data = d;
    @(negedge clk);
    buf_we = 1'b0;
    @(negedge clk);
  endtask

  // Scan hdump first..first+n; obj_pxl after each pixel shows the previous hdump
  task automatic scan(input int first, input int n, input int hit, input logic [DW-1:0] val);
    logic [DW-1:0] e;
    for (int k = 0; k <= n; k++) begin
      pix(AW'(first + k));
      if (k > 0) begin
        e = ((first + k - 1) == hit) ? val : 8'h00;
        total_cnt++;
        if (obj_pxl !== e)
          $display("FAIL scan h=%0d: obj_pxl=%h expected %h", first + k - 1, obj_pxl, e);
        else pass_cnt++;
      end
    end
  endtask

  task automatic hblank(input logic busy, input logic exp_bank);
    LHBL = 1'b0; draw_busy = busy;
    @(negedge clk);
    total_cnt++;
    if (line_start !== 1'b1 || overrun !== busy || draw_bank !== exp_bank)
      $display("FAIL swap: ls=%b ov=%b bank=%b expected ls=1 ov=%b bank=%b",
               line_start, overrun, draw_bank, busy, exp_bank);
    else pass_cnt++;
    draw_busy = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (line_start !== 1'b0 || overrun !== 1'b0)
      $display("FAIL swap_pulse: ls=%b ov=%b expected 0 0", line_start, overrun);
    else pass_cnt++;
    pix(9'h1AA);
    total_cnt++;
    if (obj_pxl !== 8'h00) $display("FAIL blank_pxl: obj_pxl=%h expected 00", obj_pxl);
    else pass_cnt++;
    LHBL = 1'b1;
    @(negedge clk);
  endtask

  // Release reset and count clks until ready; stray writes/blanks must be ignored
  task automatic wait_clear(input string name);
    int cnt = 0;
    logic bad_pxl = 1'b0, bad_ls = 1'b0, bad_bank = 1'b0;
    rst_n = 1'b1;
    while (cnt < 2000) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (obj_pxl !== 8'h00) bad_pxl = 1'b1;
      if (line_start !== 1'b0) bad_ls = 1'b1;
      if (draw_bank !== 1'b0) bad_bank = 1'b1;
      buf_we = (cnt == 100);
      buf_addr = 9'd3; buf_data = 8'h77;
      if (cnt == 200) LHBL = 1'b0;
      if (cnt == 220) LHBL = 1'b1;
      if (ready === 1'b1) break;
    end
    buf_we = 1'b0;
    total_cnt++;
    if (cnt !== 513) $display("FAIL %s ready_latency: %0d clks expected 513", name, cnt);
    else pass_cnt++;
    total_cnt++;
    if (bad_pxl !== 1'b0) $display("FAIL %s clear_pxl: nonzero obj_pxl=%b expected 0", name, bad_pxl);
    else pass_cnt++;
    total_cnt++;
    if (bad_ls !== 1'b0 || bad_bank !== 1'b0)
      $display("FAIL %s clear_swap: ls_seen=%b bank_moved=%b expected 0 0", name, bad_ls, bad_bank);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total_cnt++;
    if (obj_pxl !== 8'h00 || line_start !== 1'b0 || overrun !== 1'b0 ||
        draw_bank !== 1'b0 || ready !== 1'b0)
      $display("FAIL reset: pxl=%h ls=%b ov=%b bank=%b rdy=%b expected 00 0 0 0 0",
               obj_pxl, line_start, overrun, draw_bank, ready);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    wait_clear("clear");
  endtask

  task automatic test_draw_scan();
    wr(9'd10, 8'h35);
    wr(9'd11, 8'h20);
    total_cnt++;
    if (draw_bank !== 1'b0) $display("FAIL draw_bank_pre: %b expected 0", draw_bank);
    else pass_cnt++;
    hblank(1'b0, 1'b1);
    scan(0, 16, 10, 8'h35);
  endtask

  task automatic test_erase();
    hblank(1'b0, 1'b0);
    hblank(1'b0, 1'b1);
    scan(9, 2, -1, 8'h00);
  endtask

  task automatic test_flip();
    wr(9'h1F0, 8'h47);
    hblank(1'b0, 1'b0);
    flip = 1'b1;
    scan(13, 4, 15, 8'h47);
    flip = 1'b0;
  endtask

  task automatic test_overrun();
    hblank(1'b1, 1'b1);
  endtask

  task automatic test_swap_write();
    LHBL = 1'b0; buf_we = 1'b1; buf_addr = 9'd20; buf_data = 8'h5A;
    @(negedge clk);
    buf_we = 1'b0;
    total_cnt++;
    if (line_start !== 1'b1 || draw_bank !== 1'b0)
      $display("FAIL swap_write_swap: ls=%b bank=%b expected 1 0", line_start, draw_bank);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    LHBL = 1'b1;
    @(negedge clk);
    scan(19, 2, 20, 8'h5A);
  endtask

  task automatic test_reset_mid();
    wr(9'd30, 8'hFF);
    total_cnt++;
    if (obj_pxl !== 8'h5A) $display("FAIL pre_reset_pxl: obj_pxl=%h expected 5a", obj_pxl);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (obj_pxl !== 8'h00 || ready !== 1'b0)
      $display("FAIL reset_mid: pxl=%h rdy=%b expected 00 0", obj_pxl, ready);
    else pass_cnt++;
    @(negedge clk);
    wait_clear("reclear");
    hblank(1'b0, 1'b1);
    scan(29, 2, -1, 8'h00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clear();
    test_draw_scan();
    test_erase();
    test_flip();
    test_overrun();
    test_swap_write();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
